// File: rtl/aca16_xor_enc32.sv
// Logic-locked 16-bit Almost Correct Adder with a 32-bit XOR/XNOR key-gate lock.
// Each sum bit uses a speculative carry rippled only over the WINDOW bits below it.
// The 16 propagate and 16 generate nets each pass through their own key gate.
// The {carry_out, sum} result is registered, giving one cycle of latency.
module aca16_xor_enc32 #(
  parameter int unsigned WINDOW      = 4,
  parameter logic [31:0] CORRECT_KEY = 32'h1812B8A4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] add1_i,
  input  logic [15:0] add2_i,
  input  logic [31:0] keyinput,
  output logic [16:0] result_o
);

  localparam int Win = int'(WINDOW);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] sum_d;
  logic        cout_d;
  logic [16:0] result_q;

  // One key gate per net. Its type is fixed by CORRECT_KEY, so the correct key leaves
  // every net equal to its true propagate or generate value.
  for (genvar i = 0; i < 16; i++) begin : g_bit
    logic p_raw;
    logic g_raw;
    assign p_raw = add1_i[i] ^ add2_i[i];
    assign g_raw = add1_i[i] & add2_i[i];

    if (CORRECT_KEY[i]) begin : g_p_xnor
      assign p[i] = ~(p_raw ^ keyinput[i]);
    end else begin : g_p_xor
      assign p[i] = p_raw ^ keyinput[i];
    end

    if (CORRECT_KEY[16+i]) begin : g_g_xnor
      assign g[i] = ~(g_raw ^ keyinput[16+i]);
    end else begin : g_g_xor
      assign g[i] = g_raw ^ keyinput[16+i];
    end
  end

  // Ripple carry into bit hi from bits max(0, hi-Win)..hi-1, carry-in 0 at the low end.
  function automatic logic win_carry(input logic [15:0] pp, input logic [15:0] gg,
                                     input int hi);
    logic c;
    int   lo;
    c  = 1'b0;
    lo = (hi > Win) ? hi - Win : 0;
    for (int j = 0; j < 16; j++) begin
      if (j >= lo && j < hi) c = gg[j] | (pp[j] & c);
    end
    return c;
  endfunction

  // Speculative sum bits and truncated carry out.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 16; i++) begin
      sum_d[i] = p[i] ^ win_carry(p, g, i);
    end
    cout_d = win_carry(p, g, 16);
  end

  // Result register; reset clears it and drops any result still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
    end else begin
      result_q <= {cout_d, sum_d};
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_aca16_xor_enc32.sv
// Scoreboard bench for aca16_xor_enc32.
// The driver applies inputs on falling edges and queues the expected result.
// The monitor pops and compares one result #1 after each rising edge.
module tb_aca16_xor_enc32;

  localparam int          Win  = 4;
  localparam logic [31:0] KeyOk = 32'h1812B8A4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] add1_i = 16'h29AF;
  logic [15:0] add2_i = 16'h7A1B;
  logic [31:0] keyinput = KeyOk;
  logic [16:0] result_o;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  aca16_xor_enc32 #(
    .WINDOW      (Win),
    .CORRECT_KEY (KeyOk)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .keyinput (keyinput),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h, expected %05h", tag, got, exp);
    end
  endtask

  // Arithmetic ACA model: carry into bit i is the carry out of a plain add of the
  // Win-bit operand slices just below i. Valid with the correct key only.
  function automatic logic [16:0] aca_model(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    int lo, n, s, mask, c;
    r = '0;
    for (int i = 0; i <= 16; i++) begin
      lo = (i > Win) ? i - Win : 0;
      n  = i - lo;
      if (n == 0) begin
        c = 0;
      end else begin
        mask = (1 << n) - 1;
        s = ((int'(a) >> lo) & mask) + ((int'(b) >> lo) & mask);
        c = (s >> n) & 1;
      end
      if (i < 16) r[i] = a[i] ^ b[i] ^ c[0];
      else        r[16] = c[0];
    end
    return r;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k,
                       input logic [16:0] exp);
    @(negedge clk_i);
    add1_i   = a;
    add2_i   = b;
    keyinput = k;
    exp_q.push_back(exp);
  endtask

  // Monitor: one result per rising edge while out of reset.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("pipe", result_o, e);
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    int          guard;

    // Reset holds the output at zero across edges.
    #3 check_eq("rst_async", result_o, 17'h00000);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rst_hold", result_o, 17'h00000);
    rst_i = 1'b0;
    exp_q.push_back(17'h0A3CA);

    // Back-to-back directed vectors, then key changes mid-stream.
    drive(16'h5555, 16'hAAAA, KeyOk, 17'h0FFFF);
    drive(16'h1111, 16'hEEAA, KeyOk, 17'h0FFBB);
    drive(16'hABCD, 16'h0000, KeyOk, 17'h0ABCD);
    drive(16'h0000, 16'h1234, KeyOk, 17'h01234);
    drive(16'h0001, 16'hFFFF, KeyOk, 17'h0FFE0);
    drive(16'h00FF, 16'h0001, KeyOk, 17'h000E0);
    drive(16'h0000, 16'h0000, 32'h1812B8A5, 17'h00001);
    drive(16'h0000, 16'h0000, 32'h1813B8A4, 17'h00002);
    drive(16'h0000, 16'h0000, KeyOk, 17'h00000);
    drive(16'hFFFF, 16'hFFFF, KeyOk, aca_model(16'hFFFF, 16'hFFFF));
    drive(16'h000F, 16'h0001, KeyOk, 17'h00010);

    // Random correct-key traffic against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive(ra, rb, KeyOk, aca_model(ra, rb));
    end

    // Drain the queue (bounded).
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk_i);
      guard++;
    end
    check_eq("drain", 17'(exp_q.size()), 17'h00000);

    // Mid-cycle reset discards the pending result and clears the output at once.
    @(negedge clk_i);
    add1_i = 16'h1234;
    add2_i = 16'h4321;
    #2 rst_i = 1'b1;
    #1 check_eq("rst_mid", result_o, 17'h00000);
    @(posedge clk_i);
    #1 check_eq("rst_mid_hold", result_o, 17'h00000);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.push_back(17'h05555);
    @(negedge clk_i);
    check_eq("post_rst_q", 17'(exp_q.size()), 17'h00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the run never finishes.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
